// File: rtl/cache_req_arbiter3_if.sv
// Bundle of the three requester channels, the consumer channel and the occupancy
// output of cache_req_arbiter3.
interface cache_req_arbiter3_if #(
    parameter int DW    = 5,
    parameter int DEPTH = 4
);
    logic                     i_valid0;
    logic [DW-1:0]            i_data0;
    logic                     o_ready0;
    logic                     i_valid1;
    logic [DW-1:0]            i_data1;
    logic                     o_ready1;
    logic                     i_valid2;
    logic [DW-1:0]            i_data2;
    logic                     o_ready2;
    logic                     o_valid;
    logic [DW-1:0]            o_data;
    logic [1:0]               o_src;
    logic                     i_ready;
    logic [$clog2(DEPTH):0]   o_count;

    modport slave (
        input  i_valid0, i_data0, i_valid1, i_data1, i_valid2, i_data2, i_ready,
        output o_ready0, o_ready1, o_ready2, o_valid, o_data, o_src, o_count
    );

    modport master (
        output i_valid0, i_data0, i_valid1, i_data1, i_valid2, i_data2, i_ready,
        input  o_ready0, o_ready1, o_ready2, o_valid, o_data, o_src, o_count
    );
endinterface

// File: rtl/cache_req_arbiter3.sv
// Three-way request arbiter (round-robin or fixed priority) feeding a small FIFO
// that tags every entry with the source requester id.
module cache_req_arbiter3 #(
    parameter int DW    = 5,
    parameter int DEPTH = 4,
    parameter int RR_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_req_arbiter3_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    logic [DW+1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic [1:0]    rr_ptr;
    logic [1:0]    base, idx, gnt_idx;
    logic [2:0]    req_v, gnt;
    logic [DW-1:0] win_data;
    logic [DW+1:0] head;
    logic          full, push, pop;

    assign req_v = {bus.i_valid2, bus.i_valid1, bus.i_valid0};
    assign full  = (count == CW'(DEPTH));

    // Search from the base pointer; a full FIFO refuses even if a pop frees a slot this cycle
    always_comb begin
        gnt     = 3'b000;
        gnt_idx = 2'd0;
        idx     = 2'd0;
        base    = (RR_EN != 0) ? rr_ptr : 2'd0;
        if (!rst && !full) begin
            for (int off = 0; off < 3; off++) begin
                idx = mod3_add(base, 2'(off));
                if (req_v[idx] && (gnt == 3'b000)) begin
                    gnt     = 3'(3'b001 << idx);
                    gnt_idx = idx;
                end
            end
        end
    end

    always_comb begin
        case (gnt_idx)
            2'd0:    win_data = bus.i_data0;
            2'd1:    win_data = bus.i_data1;
            default: win_data = bus.i_data2;
        endcase
    end

    assign push = |gnt;
    assign pop  = (count != '0) && bus.i_ready;

    // Storage carries no reset; occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {gnt_idx, win_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            rr_ptr <= 2'd0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if ((RR_EN != 0) && push) rr_ptr <= mod3_add(gnt_idx, 2'd1);
        end
    end

    assign head         = mem[rptr];
    assign bus.o_ready0 = gnt[0];
    assign bus.o_ready1 = gnt[1];
    assign bus.o_ready2 = gnt[2];
    assign bus.o_valid  = (count != '0);
    assign bus.o_data   = bus.o_valid ? head[DW-1:0] : '0;
    assign bus.o_src    = bus.o_valid ? head[DW+1:DW] : 2'd0;
    assign bus.o_count  = count;
endmodule

// File: tb/tb_cache_req_arbiter3.sv
// Drives a round-robin and a fixed-priority instance with identical stimulus and
// checks both against a reference model with a per-instance scoreboard queue.
module tb_cache_req_arbiter3;
    localparam int DW    = 5;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]    v;
    logic [DW-1:0] d0, d1, d2;
    logic          rdy;

    cache_req_arbiter3_if #(.DW(DW), .DEPTH(DEPTH)) bus_rr ();
    cache_req_arbiter3_if #(.DW(DW), .DEPTH(DEPTH)) bus_fp ();

    assign bus_rr.i_valid0 = v[0]; assign bus_rr.i_data0 = d0;
    assign bus_rr.i_valid1 = v[1]; assign bus_rr.i_data1 = d1;
    assign bus_rr.i_valid2 = v[2]; assign bus_rr.i_data2 = d2;
    assign bus_rr.i_ready  = rdy;
    assign bus_fp.i_valid0 = v[0]; assign bus_fp.i_data0 = d0;
    assign bus_fp.i_valid1 = v[1]; assign bus_fp.i_data1 = d1;
    assign bus_fp.i_valid2 = v[2]; assign bus_fp.i_data2 = d2;
    assign bus_fp.i_ready  = rdy;

    cache_req_arbiter3 #(.DW(DW), .DEPTH(DEPTH), .RR_EN(1)) dut_rr (
        .clk(clk), .rst(rst), .bus(bus_rr.slave));
    cache_req_arbiter3 #(.DW(DW), .DEPTH(DEPTH), .RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst), .bus(bus_fp.slave));

    int            ncmp = 0;
    int            nfail = 0;
    logic [1:0]    m_p;
    logic [DW+1:0] q_rr [$];
    logic [DW+1:0] q_fp [$];
    logic [2:0]    eg [2];

    typedef struct {
        logic       r;
        logic [2:0] vv;
        logic       rd;
        logic [2:0] exp_rr;
        logic [2:0] exp_fp;
        int         exp_cnt;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_grant(input logic [2:0] vv, input logic [1:0] p,
                                             input int cnt, input logic r);
        int k;
        if (r || cnt == DEPTH) return 3'b000;
        for (int off = 0; off < 3; off++) begin
            k = (int'(p) + off) % 3;
            if (vv[k]) return 3'(1 << k);
        end
        return 3'b000;
    endfunction

    task automatic check_one(input int d);
        logic [2:0]    ar, g;
        logic          av;
        logic [DW-1:0] ad;
        logic [1:0]    as;
        int            ac, cnt, k;
        logic [DW+1:0] front;
        logic [DW-1:0] wd;
        string         tag;
        tag = (d == 0) ? "rr" : "fp";
        if (d == 0) begin
            ar = {bus_rr.o_ready2, bus_rr.o_ready1, bus_rr.o_ready0};
            av = bus_rr.o_valid; ad = bus_rr.o_data; as = bus_rr.o_src;
            ac = int'(bus_rr.o_count); cnt = q_rr.size();
        end else begin
            ar = {bus_fp.o_ready2, bus_fp.o_ready1, bus_fp.o_ready0};
            av = bus_fp.o_valid; ad = bus_fp.o_data; as = bus_fp.o_src;
            ac = int'(bus_fp.o_count); cnt = q_fp.size();
        end
        g = exp_grant(v, (d == 0) ? m_p : 2'd0, cnt, rst);
        chk({tag, "_ready"}, int'(ar), int'(g));
        chk({tag, "_valid"}, int'(av), int'(cnt != 0));
        chk({tag, "_count"}, ac, cnt);
        if (cnt == 0) begin
            chk({tag, "_idle_data"}, int'(ad), 0);
            chk({tag, "_idle_src"}, int'(as), 0);
        end else if (rdy) begin
            front = (d == 0) ? q_rr.pop_front() : q_fp.pop_front();
            chk({tag, "_pop_data"}, int'(ad), int'(front[DW-1:0]));
            chk({tag, "_pop_src"}, int'(as), int'(front[DW+1:DW]));
        end
        if (g != 3'b000) begin
            k  = g[0] ? 0 : (g[1] ? 1 : 2);
            wd = (k == 0) ? d0 : ((k == 1) ? d1 : d2);
            if (d == 0) begin
                q_rr.push_back({2'(k), wd});
                m_p = 2'((k + 1) % 3);
            end else begin
                q_fp.push_back({2'(k), wd});
            end
        end
        if (rst) begin
            if (d == 0) begin q_rr.delete(); m_p = 2'd0; end
            else q_fp.delete();
        end
        eg[d] = g;
    endtask

    task automatic drive(input logic r, input logic [2:0] vv, input logic rd);
        rst = r; v = vv; rdy = rd;
        @(negedge clk);
    endtask

    task automatic finish_cycle();
        check_one(0);
        check_one(1);
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic r, input logic [2:0] vv, input logic rd);
        drive(r, vv, rd);
        finish_cycle();
    endtask

    initial begin
        //        rst  valid  rdy  rr_ready fp_ready count
        tbl[0]  = '{1'b1, 3'b111, 1'b1, 3'b000, 3'b000, 0};
        tbl[1]  = '{1'b1, 3'b111, 1'b1, 3'b000, 3'b000, 0};
        tbl[2]  = '{1'b0, 3'b111, 1'b1, 3'b001, 3'b001, 0};
        tbl[3]  = '{1'b0, 3'b111, 1'b1, 3'b010, 3'b001, 1};
        tbl[4]  = '{1'b0, 3'b111, 1'b1, 3'b100, 3'b001, 1};
        tbl[5]  = '{1'b0, 3'b111, 1'b1, 3'b001, 3'b001, 1};
        tbl[6]  = '{1'b0, 3'b111, 1'b1, 3'b010, 3'b001, 1};
        tbl[7]  = '{1'b0, 3'b111, 1'b1, 3'b100, 3'b001, 1};
        tbl[8]  = '{1'b0, 3'b111, 1'b1, 3'b001, 3'b001, 1};
        tbl[9]  = '{1'b0, 3'b110, 1'b1, 3'b010, 3'b010, 1};
        tbl[10] = '{1'b0, 3'b110, 1'b1, 3'b100, 3'b010, 1};
        tbl[11] = '{1'b0, 3'b100, 1'b1, 3'b100, 3'b100, 1};
        tbl[12] = '{1'b0, 3'b000, 1'b1, 3'b000, 3'b000, 1};
        tbl[13] = '{1'b0, 3'b000, 1'b1, 3'b000, 3'b000, 0};

        m_p = 2'd0;
        d0 = 5'h01; d1 = 5'h02; d2 = 5'h03;
        rst = 1'b1; v = 3'b111; rdy = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].r, tbl[i].vv, tbl[i].rd);
            chk($sformatf("tbl%0d_rr_ready", i),
                int'({bus_rr.o_ready2, bus_rr.o_ready1, bus_rr.o_ready0}), int'(tbl[i].exp_rr));
            chk($sformatf("tbl%0d_fp_ready", i),
                int'({bus_fp.o_ready2, bus_fp.o_ready1, bus_fp.o_ready0}), int'(tbl[i].exp_fp));
            chk($sformatf("tbl%0d_rr_count", i), int'(bus_rr.o_count), tbl[i].exp_cnt);
            chk($sformatf("tbl%0d_fp_count", i), int'(bus_fp.o_count), tbl[i].exp_cnt);
            finish_cycle();
        end

        // Fill to full with the consumer stalled, then drain; data 5 waits for a free slot
        d0 = 5'd1;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 3'b001, 1'b0);
            if (eg[0][0]) d0 = d0 + 5'd1;
        end
        chk("full_count", int'(bus_rr.o_count), 4);
        chk("full_ready0", int'(bus_rr.o_ready0), 0);
        chk("full_waiting", int'(d0), 5);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, {2'b00, (d0 <= 5'd5)}, 1'b1);
            if (eg[0][0]) d0 = d0 + 5'd1;
        end
        chk("full_drained", int'(bus_rr.o_count), 0);

        // Steady push+pop at occupancy 2, long enough to wrap the pointers twice
        d0 = 5'd10;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 3'b001, 1'b0);
            if (eg[0][0]) d0 = d0 + 5'd1;
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 3'b001, 1'b1);
            if (eg[0][0]) d0 = d0 + 5'd1;
            chk("stream_count", int'(bus_rr.o_count), 2);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'b000, 1'b1);

        // Reset with three entries queued; none of them may surface afterwards
        d0 = 5'd20;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 3'b001, 1'b0);
            if (eg[0][0]) d0 = d0 + 5'd1;
        end
        chk("pre_rst_count", int'(bus_rr.o_count), 3);
        cycle(1'b1, 3'b111, 1'b0);
        chk("post_rst_valid", int'(bus_rr.o_valid), 0);
        chk("post_rst_count", int'(bus_rr.o_count), 0);
        d0 = 5'd7; d1 = 5'd8; d2 = 5'd9;
        drive(1'b0, 3'b111, 1'b1);
        chk("post_rst_grant", int'({bus_rr.o_ready2, bus_rr.o_ready1, bus_rr.o_ready0}), 1);
        finish_cycle();
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'b111, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'b000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/cache_req_arbiter3.md
Name: cache_req_arbiter3

Overview:
- Synchronous three-requester arbiter and merge buffer for 5-bit cache request tags (e.g. MSHR/way indices).
- Selects one of three valid/ready sources per cycle (round-robin or fixed priority) and writes the winning payload plus a 2-bit source tag into an internal FIFO.
- The FIFO drains to a single valid/ready consumer.
- Sits between the cache request producers and the downstream pipeline; it integrates the merge and the trailing FIFO that the merge depends on.

Parameters:
DW, 5, payload width per requester
DEPTH, 4, FIFO entries; power of two, >=2
RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority 0>1>2

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous reset, active-high
i_valid0  input  1  requester 0 has data
i_data0  input  DW  requester 0 payload
o_ready0  output  1  requester 0 transfer accepted this cycle
i_valid1  input  1  requester 1 has data
i_data1  input  DW  requester 1 payload
o_ready1  output  1  requester 1 accepted
i_valid2  input  1  requester 2 has data
i_data2  input  DW  requester 2 payload
o_ready2  output  1  requester 2 accepted
o_valid  output  1  FIFO head valid
o_data  output  DW  FIFO head payload
o_src  output  2  FIFO head source id (0/1/2)
i_ready  input  1  consumer accepts head
o_count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst=1 at a clock edge): occupancy=0, read/write pointers=0, RR pointer=0 (requester 0 highest priority).
  - o_valid=0, o_data=0, o_src=0, o_count=0.
  - o_ready0..2 forced 0 while rst=1.
  - Reset mid-operation discards all FIFO contents.
- Handshake: transfer on a channel when valid&ready at a rising edge. Requesters hold valid and data stable until accepted. The consumer may drop i_ready at any time.
- Grant logic (combinational from i_valid*, RR pointer, full):
  - full = (count==DEPTH).
  - If full, or no valid: all o_ready=0.
  - Otherwise exactly one o_ready_k=1, for the highest-priority valid requester.
  - No pass-through: a push is refused when full, even if a pop occurs the same cycle.
- RR_EN=1: priority order starts at the RR pointer p: p, p+1, p+2 (mod 3). After a grant to k, p <= (k+1) mod 3. p is unchanged when no grant occurs.
- RR_EN=0: fixed order 0,1,2; no pointer state.
- Push: on a grant to k, write {k, i_data_k} at wptr; wptr increments mod DEPTH.
- Pop: on o_valid&i_ready, rptr increments mod DEPTH.
- Occupancy:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop in the same cycle: count unchanged, pointers both advance.
  - Push and pop in the same cycle is legal at any 0<count<DEPTH. At count==0 only a push can occur.
- Outputs:
  - o_valid = (count!=0).
  - o_data/o_src = head entry when o_valid, else 0.
  - o_count is a registered occupancy.
- Latency: an item accepted at edge N is visible on o_valid/o_data after edge N, so it is poppable at edge N+1 at the earliest. Minimum latency is 1 cycle.
- Throughput: 1 push and 1 pop per cycle sustained.
- Ordering: strict FIFO order across all sources. Per-source order is preserved.
- No starvation (RR_EN=1): a continuously valid requester is granted within 3 grant cycles.

Test Plan:
- Reset: assert rst for 2 cycles with all i_valid=1 -> o_ready0..2=0, o_valid=0, o_count=0, o_data=0. After release, the first grant goes to requester 0.
- RR fairness (RR_EN=1): i_valid0..2=1 constantly, data 0x01/0x02/0x03, i_ready=1 -> o_src sequence 0,1,2,0,1,2 with matching data. o_count stays 1 after the first cycle.
- Fixed priority (RR_EN=0): all valid, i_ready=1 -> o_ready0 every cycle, o_ready1/o_ready2 never. Drop i_valid0 -> requester 1 is granted.
- Full boundary: i_ready=0, requester 0 presents data 1,2,3,4,5 -> 4 accepted, o_count=4, o_ready0=0 while 5 waits. Then raise i_ready with i_valid0 held -> outputs 1,2,3,4. Data 5 is accepted on the first cycle after count drops below 4 (no same-cycle push at full).
- Simultaneous push/pop: count=2, one valid requester, i_ready=1 for 10 cycles -> o_count stays 2, all data in order, pointers wrap past DEPTH without loss.
- Mid-operation reset: count=3, assert rst for 1 cycle -> o_valid=0, o_count=0. Old entries never appear. The next grant goes to requester 0.
